// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg: stall-bit indices, stall encodings, FSM states and opcode classes for the ID stage.
package id_operand_stage_pkg;
  localparam int STALL_IFID = 1;
  localparam int STALL_IDEX = 2;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [2:0] OP_STORE_HI = 3'b101;
  function automatic logic rt_used(input logic [5:0] op);
    return op == OP_SPECIAL || op == OP_BEQ || op == OP_BNE || op[5:3] == OP_STORE_HI;
  endfunction
  function automatic logic rs_used(input logic [5:0] op);
    return !(op == OP_J || op == OP_JAL || op == OP_LUI);
  endfunction
endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// fwd_mux: selects one operand from N_FWD forwarding channels (index 0 wins) or the regfile.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int N_FWD = 3
) (
  input  logic [4:0]              addr_i,
  input  logic [DATA_W-1:0]       rf_data_i,
  input  logic [N_FWD-1:0]        we_i,
  input  logic [N_FWD-1:0]        ready_i,
  input  logic [5*N_FWD-1:0]      waddr_i,
  input  logic [DATA_W*N_FWD-1:0] wdata_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    ready_o
);
  always_comb begin
    data_o = rf_data_i;
    ready_o = 1'b1;
    // Walk from lowest priority upward so the lowest-index match is applied last.
    for (int k = N_FWD - 1; k >= 0; k--) begin
      if (we_i[k] && waddr_i[5*k +: 5] != 5'd0 && waddr_i[5*k +: 5] == addr_i) begin
        data_o = wdata_i[DATA_W*k +: DATA_W];
        ready_o = ready_i[k];
      end
    end
    data_o = (addr_i == 5'd0) ? '0 : data_o;
    ready_o = (addr_i == 5'd0) ? 1'b1 : ready_o;
  end
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: IF/ID register with instruction hold buffer, operand forwarding and load-use stall detection.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W = 32,
  parameter int N_FWD = 3,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic                    flush,
  input  logic                    if_valid,
  input  logic [PC_W-1:0]         if_pc,
  input  logic [31:0]             inst_sram_rdata,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [DATA_W-1:0]       rf_rdata1,
  input  logic [DATA_W-1:0]       rf_rdata2,
  input  logic [N_FWD-1:0]        fwd_we,
  input  logic [N_FWD-1:0]        fwd_ready,
  input  logic [5*N_FWD-1:0]      fwd_waddr,
  input  logic [DATA_W*N_FWD-1:0] fwd_wdata,
  output logic                    id_valid,
  output logic [PC_W-1:0]         id_pc,
  output logic [31:0]             id_inst,
  output logic [DATA_W-1:0]       opnd1,
  output logic [DATA_W-1:0]       opnd2,
  output logic                    stallreq,
  output logic [CNT_W-1:0]        stall_cycles
);
  state_t state_q, state_d;
  logic valid_q, valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic rdy1, rdy2;
  logic stop_ifid, stop_idex;
  assign stop_ifid = stall[STALL_IFID] == STOP;
  assign stop_idex = stall[STALL_IDEX] == STOP;
  assign id_valid = valid_q;
  assign id_pc = pc_q;
  // The fetch data is only live for one cycle, so a held instruction is replayed from buf_q.
  assign id_inst = valid_q ? (state_q == HOLD ? buf_q : inst_sram_rdata) : '0;
  assign rf_raddr1 = id_inst[25:21];
  assign rf_raddr2 = id_inst[20:16];
  assign stall_cycles = cnt_q;
  assign stallreq = valid_q && !flush &&
                    ((rs_used(id_inst[31:26]) && !rdy1) || (rt_used(id_inst[31:26]) && !rdy2));
  fwd_mux #(.DATA_W(DATA_W), .N_FWD(N_FWD)) u_fwd_rs (
    .addr_i(rf_raddr1), .rf_data_i(rf_rdata1), .we_i(fwd_we), .ready_i(fwd_ready),
    .waddr_i(fwd_waddr), .wdata_i(fwd_wdata), .data_o(opnd1), .ready_o(rdy1)
  );
  fwd_mux #(.DATA_W(DATA_W), .N_FWD(N_FWD)) u_fwd_rt (
    .addr_i(rf_raddr2), .rf_data_i(rf_rdata2), .we_i(fwd_we), .ready_i(fwd_ready),
    .waddr_i(fwd_waddr), .wdata_i(fwd_wdata), .data_o(opnd2), .ready_o(rdy2)
  );
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    if (flush) state_d = RUN;
    else if (state_q == RUN && stop_ifid && valid_q) begin
      state_d = HOLD;
      buf_d = inst_sram_rdata;
    end else if (state_q == HOLD && !stop_ifid) state_d = RUN;
    valid_d = valid_q;
    pc_d = pc_q;
    if (flush || (stop_ifid && !stop_idex)) begin
      valid_d = 1'b0;
      pc_d = '0;
    end else if (!stop_ifid) begin
      valid_d = if_valid;
      pc_d = if_pc;
    end
    cnt_d = (stallreq && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      pc_q <= '0;
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q <= pc_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed checks of IF/ID holding, forwarding priority, load-use stall and counter saturation.
module tb_id_operand_stage;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] stall;
  logic flush;
  logic if_valid;
  logic [31:0] if_pc;
  logic [31:0] inst_sram_rdata;
  logic [4:0] rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0] fwd_we, fwd_ready;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic id_valid;
  logic [31:0] id_pc, id_inst, opnd1, opnd2;
  logic stallreq;
  logic [3:0] stall_cycles;
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_operand_stage #(.DATA_W(32), .PC_W(32), .N_FWD(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
    .inst_sram_rdata(inst_sram_rdata), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we), .fwd_ready(fwd_ready),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .opnd1(opnd1), .opnd2(opnd2), .stallreq(stallreq),
    .stall_cycles(stall_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_inst(input logic [31:0] pc, input logic [31:0] inst);
    stall = 6'b0;
    flush = 1'b0;
    if_valid = 1'b1;
    if_pc = pc;
    tick();
    inst_sram_rdata = inst;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    fwd_we = 3'b0;
    fwd_ready = 3'b111;
    fwd_waddr = '0;
    fwd_wdata = '0;
    stall = 6'b0;
    flush = 1'b0;
    if_valid = 1'b0;
    if_pc = 32'h0;
    inst_sram_rdata = 32'hFFFF_FFFF;
    rf_rdata1 = 32'hAAAA_AAAA;
    rf_rdata2 = 32'hBBBB_BBBB;
    do_reset();
    #1;
    n_run++;
    if ({id_valid, id_pc, id_inst, opnd1, opnd2, stallreq, stall_cycles, rf_raddr1, rf_raddr2} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b pc=%h inst=%h op1=%h op2=%h sr=%0b cnt=%0d, required all 0",
               id_valid, id_pc, id_inst, opnd1, opnd2, stallreq, stall_cycles);
    end
  endtask

  task automatic test_fwd_priority();
    // addiu rs=5 rt=0
    fwd_we = 3'b011;
    fwd_ready = 3'b111;
    fwd_waddr = {5'd0, 5'd5, 5'd5};
    fwd_wdata = {32'h0, 32'h22, 32'h11};
    load_inst(32'h40, 32'h24A0_0001);
    n_run++;
    if (rf_raddr1 !== 5'd5) begin n_fail++; $display("FAIL raddr1: got %0d want 5", rf_raddr1); end
    n_run++;
    if (opnd1 !== 32'h11) begin n_fail++; $display("FAIL fwd_ch0_wins: got %h want 00000011", opnd1); end
    n_run++;
    if (stallreq !== 1'b0) begin n_fail++; $display("FAIL fwd_ch0_stall: got %0b want 0", stallreq); end
    n_run++;
    if (opnd2 !== 32'h0) begin n_fail++; $display("FAIL addr0_zero: got %h want 00000000", opnd2); end
    fwd_we = 3'b010;
    #1;
    n_run++;
    if (opnd1 !== 32'h22) begin n_fail++; $display("FAIL fwd_ch1: got %h want 00000022", opnd1); end
    fwd_we = 3'b011;
    fwd_ready = 3'b101;
    #1;
    n_run++;
    if (stallreq !== 1'b0) begin n_fail++; $display("FAIL masked_notready: got %0b want 0", stallreq); end
    fwd_we = 3'b010;
    #1;
    n_run++;
    if (stallreq !== 1'b1) begin n_fail++; $display("FAIL ch1_notready: got %0b want 1", stallreq); end
    fwd_we = 3'b000;
    #1;
    n_run++;
    if (opnd1 !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL rf_fallback: got %h want aaaaaaaa", opnd1); end
  endtask

  task automatic test_load_use();
    // addu rd=10, rs=8, rt=9
    fwd_we = 3'b001;
    fwd_ready = 3'b110;
    fwd_waddr = {5'd0, 5'd0, 5'd8};
    fwd_wdata = {32'h0, 32'h0, 32'h88};
    load_inst(32'h80, 32'h0109_5021);
    n_run++;
    if (stallreq !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %0b want 1", stallreq); end
    flush = 1'b1;
    #1;
    n_run++;
    if (stallreq !== 1'b0) begin n_fail++; $display("FAIL flush_masks_stall: got %0b want 0", stallreq); end
    flush = 1'b0;
    fwd_ready = 3'b111;
    #1;
    n_run++;
    if (stallreq !== 1'b0 || opnd1 !== 32'h88) begin
      n_fail++;
      $display("FAIL load_ready: sr=%0b op1=%h, want sr=0 op1=00000088", stallreq, opnd1);
    end
    n_run++;
    if (opnd2 !== 32'hBBBB_BBBB) begin n_fail++; $display("FAIL rt_regfile: got %h want bbbbbbbb", opnd2); end
  endtask

  task automatic test_rt_unused();
    fwd_we = 3'b001;
    fwd_ready = 3'b110;
    fwd_waddr = {5'd0, 5'd0, 5'd9};
    fwd_wdata = {32'h0, 32'h0, 32'h99};
    load_inst(32'hC0, 32'h3C09_1234);
    n_run++;
    if (stallreq !== 1'b0) begin n_fail++; $display("FAIL lui_rt_unused: got %0b want 0", stallreq); end
    // sw rs=3 rt=9 uses rt
    load_inst(32'hC4, 32'hAC69_0000);
    n_run++;
    if (stallreq !== 1'b1) begin n_fail++; $display("FAIL sw_rt_used: got %0b want 1", stallreq); end
    fwd_we = 3'b000;
  endtask

  task automatic test_hold();
    load_inst(32'h100, 32'h2402_0005);
    stall = 6'b000110;
    tick();
    inst_sram_rdata = 32'hDEAD_BEEF;
    #1;
    n_run++;
    if (id_inst !== 32'h2402_0005 || id_valid !== 1'b1 || id_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL hold_cycle1: inst=%h v=%0b pc=%h, want 24020005 1 00000100", id_inst, id_valid, id_pc);
    end
    tick();
    n_run++;
    if (id_inst !== 32'h2402_0005) begin n_fail++; $display("FAIL hold_cycle2: got %h want 24020005", id_inst); end
    if_pc = 32'h104;
    stall = 6'b0;
    tick();
    n_run++;
    if (id_inst !== 32'hDEAD_BEEF || id_pc !== 32'h104) begin
      n_fail++;
      $display("FAIL hold_resume: inst=%h pc=%h, want deadbeef 00000104", id_inst, id_pc);
    end
    stall = 6'b000010;
    tick();
    n_run++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL bubble: v=%0b pc=%h inst=%h, want all 0", id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_flush_reset();
    load_inst(32'h200, 32'h2402_0005);
    stall = 6'b000110;
    flush = 1'b1;
    tick();
    n_run++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_over_stall: v=%0b pc=%h, want 0 0", id_valid, id_pc);
    end
    flush = 1'b0;
    load_inst(32'h300, 32'h2402_0007);
    stall = 6'b000110;
    tick();
    inst_sram_rdata = 32'h1234_5678;
    rst = 1'b0;
    tick();
    n_run++;
    if ({id_valid, id_pc, id_inst, opnd1, opnd2, stallreq, stall_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_hold: v=%0b pc=%h inst=%h op1=%h op2=%h, want all 0", id_valid, id_pc, id_inst, opnd1, opnd2);
    end
    rst = 1'b1;
    load_inst(32'h304, 32'h1234_5678);
    n_run++;
    if (id_inst !== 32'h1234_5678) begin n_fail++; $display("FAIL post_reset_inst: got %h want 12345678", id_inst); end
  endtask

  task automatic test_saturate();
    do_reset();
    fwd_we = 3'b001;
    fwd_ready = 3'b110;
    fwd_waddr = {5'd0, 5'd0, 5'd8};
    load_inst(32'h400, 32'h0109_5021);
    stall = 6'b000110;
    n_run++;
    if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL cnt_start: got %0d want 0", stall_cycles); end
    repeat (5) tick();
    n_run++;
    if (stall_cycles !== 4'd5) begin n_fail++; $display("FAIL cnt_5: got %0d want 5", stall_cycles); end
    repeat (15) tick();
    n_run++;
    if (stall_cycles !== 4'd15) begin n_fail++; $display("FAIL cnt_sat: got %0d want 15", stall_cycles); end
    repeat (3) tick();
    n_run++;
    if (stall_cycles !== 4'd15) begin n_fail++; $display("FAIL cnt_nowrap: got %0d want 15", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_rt_unused();
    test_hold();
    test_flush_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/id_operand_stage.md
ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/forwarding data width.
REQ-002 Parameter PC_W, default 32, PC width.
REQ-003 Parameter N_FWD, default 3, number of forwarding channels; index 0 is highest priority (EX, MEM, WB order).
REQ-004 Parameter CNT_W, default 16, width of stall-cycle counter.
REQ-005 One clock; reset is synchronous and active-low; ports: clk input 1 (rising edge), rst input 1 (synchronous, active-low).
REQ-006 stall  input  6  pipeline stall vector; bit1 = IF/ID hold, bit2 = ID/EX hold.
REQ-007 flush  input  1  branch/exception kill of the IF/ID register.
REQ-008 if_valid, if_pc  input  1, PC_W  fetch-stage valid and PC.
REQ-009 inst_sram_rdata  input  32  instruction word, valid the cycle after its PC is latched.
REQ-010 rf_raddr1, rf_raddr2  output  5, 5  regfile read addresses (inst[25:21], inst[20:16] of the selected instruction).
REQ-011 rf_rdata1, rf_rdata2  input  DATA_W  combinational regfile read data.
REQ-012 fwd_we, fwd_ready  input  N_FWD  per-channel write enable; data-available flag (0 = load result pending).
REQ-013 fwd_waddr, fwd_wdata  input  5*N_FWD, DATA_W*N_FWD  packed per-channel destination and data, channel i at slice i.
REQ-014 id_valid, id_pc, id_inst  output  1, PC_W, 32  current decode-stage instruction.
REQ-015 opnd1, opnd2  output  DATA_W  forwarded rs/rt operands.
REQ-016 stallreq  output  1  load-use hazard request to the stall controller.
REQ-017 stall_cycles  output  CNT_W  saturating count of cycles stallreq was asserted.

Function
REQ-018 IF/ID register: if stall[1] stop and stall[2] not stop, load bubble (valid 0, pc 0); else if stall[1] not stop, load if_valid/if_pc; else hold.
REQ-019 flush SHALL load a bubble on the next edge, overriding all stall conditions.
REQ-020 Two-state FSM RUN/HOLD governs the instruction source; id_inst = inst_sram_rdata in RUN, inst_buf in HOLD.
REQ-021 RUN->HOLD when stall[1] stop and id_valid: inst_buf captures inst_sram_rdata on that edge.
REQ-022 HOLD->RUN when stall[1] not stop or flush; HOLD stays HOLD otherwise; inst_buf unchanged in HOLD.
REQ-023 id_inst SHALL be 0 whenever id_valid is 0.
REQ-024 Operand i: first channel k (lowest index) with fwd_we[k], fwd_waddr[k]!=0, fwd_waddr[k]==address; else regfile data; address 0 always yields 0.
REQ-025 rt_used = opcode 000000, 000100, 000101, or 101xxx; rs_used = all opcodes except 000010, 000011, 001111.
REQ-026 stallreq = id_valid & !flush & (hazard on used rs or used rt), hazard = winning forwarding channel has fwd_ready 0.
REQ-027 Lower-priority not-ready match masked by a higher-priority ready match SHALL NOT raise stallreq.
REQ-028 stallreq and opnd1/opnd2 purely combinational from registered state and inputs; zero-cycle latency.
REQ-029 stall_cycles increments each cycle stallreq is 1, saturates at all-ones, never wraps.
REQ-030 Simultaneous flush and RUN->HOLD condition: flush wins, FSM goes/stays RUN.

Reset
REQ-031 On rst==0 at clk edge: id_valid 0, id_pc 0, inst_buf 0, FSM RUN, stall_cycles 0.
REQ-032 Reset mid-HOLD SHALL discard inst_buf; first post-reset instruction comes from inst_sram_rdata.
REQ-033 All outputs SHALL be 0 in the cycle after reset, given zero fwd_we.

Structure
REQ-034 Shared package holds stall-bit indices, Stop/NoStop encodings, FSM state encoding, opcode constants used by REQ-025.
REQ-035 One sub-module fwd_mux (one operand, N_FWD channels, returns data and ready) SHALL be instantiated twice.

Verification
REQ-036 EX ch0 we=1 waddr=5 wdata=0x11, MEM ch1 waddr=5 wdata=0x22, inst rs=5 -> opnd1=0x11, stallreq 0.
REQ-037 ch0 we=1 waddr=8 ready=0, inst addu rs=8 -> stallreq 1; set ready=1 -> stallreq 0, opnd1=ch0 data.
REQ-038 ch0 waddr=9 ready=0, inst lui rt=9 (rt unused) -> stallreq 0.
REQ-039 stall[1]=1 two cycles with inst 0x24020005 then sram data changes to 0xDEADBEEF -> id_inst stays 0x24020005, then resumes.
REQ-040 flush with stall[1]=1 -> id_valid 0, FSM RUN next cycle; rst=0 during HOLD -> all outputs 0.
REQ-041 CNT_W=4, stallreq held 20 cycles -> stall_cycles=15 and holds.
